// File: rtl/vga_timing_pkg.sv
// Package: vga_timing_pkg
// Purpose: default 640x480@60 raster constants shared by the VGA timing
//          generator and its per-axis counter. Porch/sync values are in
//          pixels (horizontal) or lines (vertical). Polarity 0 means the
//          sync pulse is driven low while asserted.
// Ports:   none (constants only).
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam bit DEF_HS_POL   = 1'b0;
  localparam bit DEF_VS_POL   = 1'b0;

  localparam int DEF_CNT_W    = 10;

endpackage

// File: rtl/vga_axis_counter.sv
// Module: vga_axis_counter
// Purpose: one raster axis. Counts 0..TOTAL-1 on each step, wrapping to 0,
//          and produces a registered sync level that lines up with the
//          registered count. Region order along the axis: active, front
//          porch, sync, back porch.
// Ports:
//   clk      in   1  pixel-rate clock
//   rst      in   1  synchronous reset, active-high (count returns to 0)
//   step     in   1  advance the count by one position this edge
//   cnt      out  W  registered position
//   cnt_nxt  out  W  position the count will hold after this edge
//   act_nxt  out  1  cnt_nxt lies in the active region
//   sync     out  1  registered sync level for cnt (POL when asserted)
//   wrap     out  1  step & (cnt == TOTAL-1): this edge returns to 0
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = DEF_HS_POL,
  parameter int W      = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         act_nxt,
  output logic         sync,
  output logic         wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  // Region bounds carry one spare bit so a sync window ending exactly at
  // TOTAL (no back porch) still fits without aliasing to 0.
  localparam logic [W:0] ACT_HI  = (W+1)'(ACTIVE);
  localparam logic [W:0] SYNC_LO = (W+1)'(ACTIVE + FP);
  localparam logic [W:0] SYNC_HI = (W+1)'(ACTIVE + FP + SYNC);

  logic       at_end;
  logic [W:0] nxt_ext;
  logic       sync_nxt;

  assign at_end = (cnt == LAST);
  assign wrap   = step & at_end;

  // Reset is folded into the next-position so every registered decode
  // (here and in the parent) lands on position 0 in the same edge.
  always_comb begin
    cnt_nxt = cnt;
    if (rst) begin
      cnt_nxt = '0;
    end else if (step) begin
      cnt_nxt = at_end ? '0 : cnt + W'(1);
    end
  end

  assign nxt_ext  = {1'b0, cnt_nxt};
  assign act_nxt  = (nxt_ext < ACT_HI);
  assign sync_nxt = ((nxt_ext >= SYNC_LO) && (nxt_ext < SYNC_HI)) ? POL : ~POL;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
    sync <= sync_nxt;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Module: vga_timing_gen
// Purpose: VGA raster timing generator. A horizontal axis counter steps on
//          every enabled pixel; the vertical axis steps when the horizontal
//          one wraps. All position-derived outputs are registered from the
//          next-position decode, so they describe the same pixel as
//          hcnt/vcnt with no pipeline skew.
// Ports:
//   clk        in   1      pixel-rate clock
//   rst        in   1      synchronous reset, active-high (wins over en)
//   en         in   1      pixel enable; nothing advances while low
//   hcnt       out  CNT_W  horizontal position 0..H_TOTAL-1
//   vcnt       out  CNT_W  vertical position 0..V_TOTAL-1
//   hsync      out  1      horizontal sync (HS_POL while asserted)
//   vsync      out  1      vertical sync (VS_POL while asserted)
//   active     out  1      position is inside the visible area
//   x          out  CNT_W  hcnt while active, else 0
//   y          out  CNT_W  vcnt while active, else 0
//   line_end   out  1      en & last pixel of the line
//   frame_end  out  1      line_end on the last line of the frame
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = DEF_HS_POL,
  parameter bit VS_POL   = DEF_VS_POL,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_end,
  output logic             frame_end
);

  // Position (0,0) is visible whenever both active regions are non-empty.
  localparam bit ORIGIN_ACTIVE = (H_ACTIVE > 0) && (V_ACTIVE > 0);

  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_act_nxt;
  logic             v_act_nxt;
  logic             h_wrap;
  logic             v_wrap;
  logic             vis_nxt;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .W      (CNT_W)
  ) u_h (
    .clk     (clk),
    .rst     (rst),
    .step    (en),
    .cnt     (hcnt),
    .cnt_nxt (h_nxt),
    .act_nxt (h_act_nxt),
    .sync    (hsync),
    .wrap    (h_wrap)
  );

  // The vertical axis steps once per completed line, so its wrap is
  // exactly the end-of-frame tick.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .W      (CNT_W)
  ) u_v (
    .clk     (clk),
    .rst     (rst),
    .step    (h_wrap),
    .cnt     (vcnt),
    .cnt_nxt (v_nxt),
    .act_nxt (v_act_nxt),
    .sync    (vsync),
    .wrap    (v_wrap)
  );

  assign vis_nxt = h_act_nxt & v_act_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= ORIGIN_ACTIVE;
      x      <= '0;
      y      <= '0;
    end else begin
      active <= vis_nxt;
      x      <= vis_nxt ? h_nxt : '0;
      y      <= vis_nxt ? v_nxt : '0;
    end
  end

  assign line_end  = h_wrap;
  assign frame_end = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench: tb_vga_timing_gen
// Three instances share one clock: default 640x480 timing, a tiny raster
// (8x6, active-high syncs) driven from a vector table, and a tall one
// (8-pixel lines, default 525-line frame) for whole-frame behaviour.
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic       d_rst = 1'b1;
  logic       d_en  = 1'b0;
  logic [9:0] d_h, d_v, d_x, d_y;
  logic       d_hs, d_vs, d_act, d_le, d_fe;

  // small instance: H 4/1/2/1, V 3/1/1/1, active-high syncs
  logic       s_rst = 1'b1;
  logic       s_en  = 1'b0;
  logic [2:0] s_h, s_v, s_x, s_y;
  logic       s_hs, s_vs, s_act, s_le, s_fe;

  // tall instance: H 4/1/2/1, default V timing
  logic       t_rst = 1'b1;
  logic       t_en  = 1'b0;
  logic [9:0] t_h, t_v, t_x, t_y;
  logic       t_hs, t_vs, t_act, t_le, t_fe;

  vga_timing_gen dut_d (
    .clk(clk), .rst(d_rst), .en(d_en), .hcnt(d_h), .vcnt(d_v),
    .hsync(d_hs), .vsync(d_vs), .active(d_act), .x(d_x), .y(d_y),
    .line_end(d_le), .frame_end(d_fe)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(3)
  ) dut_s (
    .clk(clk), .rst(s_rst), .en(s_en), .hcnt(s_h), .vcnt(s_v),
    .hsync(s_hs), .vsync(s_vs), .active(s_act), .x(s_x), .y(s_y),
    .line_end(s_le), .frame_end(s_fe)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)
  ) dut_t (
    .clk(clk), .rst(t_rst), .en(t_en), .hcnt(t_h), .vcnt(t_v),
    .hsync(t_hs), .vsync(t_vs), .active(t_act), .x(t_x), .y(t_y),
    .line_end(t_le), .frame_end(t_fe)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [2:0] h;
    logic [2:0] v;
    logic       hs;
    logic       vs;
    logic       act;
    logic [2:0] x;
    logic [2:0] y;
    logic       le;
    logic       fe;
  } vec_t;

  function automatic vec_t mk(input int rst, input int en, input int h, input int v,
                              input int hs, input int vs, input int act,
                              input int x, input int y, input int le, input int fe);
    vec_t r;
    r.rst = rst[0]; r.en = en[0];
    r.h = h[2:0];   r.v = v[2:0];
    r.hs = hs[0];   r.vs = vs[0];  r.act = act[0];
    r.x = x[2:0];   r.y = y[2:0];
    r.le = le[0];   r.fe = fe[0];
    return r;
  endfunction

  vec_t tbl[13];

  int le_cnt, le_h, hs_cnt, hs_first, hs_last, act_cnt, xy_bad;
  int fe_cnt, fe_at, vs_cnt, vs_first, vs_last;
  int exp_h, exp_v;

  initial begin
    // ------- small instance: table-driven vectors -------
    //             rst en  h v  hs vs act x y  le fe
    tbl[0]  = mk(1, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0);
    tbl[1]  = mk(0, 1,  1, 0, 0, 0, 1,  1, 0, 0, 0);
    tbl[2]  = mk(0, 1,  2, 0, 0, 0, 1,  2, 0, 0, 0);
    tbl[3]  = mk(0, 0,  2, 0, 0, 0, 1,  2, 0, 0, 0);
    tbl[4]  = mk(0, 1,  3, 0, 0, 0, 1,  3, 0, 0, 0);
    tbl[5]  = mk(0, 1,  4, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[6]  = mk(0, 1,  5, 0, 1, 0, 0,  0, 0, 0, 0);
    tbl[7]  = mk(0, 1,  6, 0, 1, 0, 0,  0, 0, 0, 0);
    tbl[8]  = mk(0, 1,  7, 0, 0, 0, 0,  0, 0, 1, 0);
    tbl[9]  = mk(0, 0,  7, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[10] = mk(0, 1,  0, 1, 0, 0, 1,  0, 1, 0, 0);
    tbl[11] = mk(0, 1,  1, 1, 0, 0, 1,  1, 1, 0, 0);
    tbl[12] = mk(1, 1,  0, 0, 0, 0, 1,  0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      s_rst = tbl[i].rst;
      s_en  = tbl[i].en;
      tick();
      check($sformatf("s_vec%0d.hcnt", i),  32'(s_h),   32'(tbl[i].h));
      check($sformatf("s_vec%0d.vcnt", i),  32'(s_v),   32'(tbl[i].v));
      check($sformatf("s_vec%0d.hsync", i), 32'(s_hs),  32'(tbl[i].hs));
      check($sformatf("s_vec%0d.vsync", i), 32'(s_vs),  32'(tbl[i].vs));
      check($sformatf("s_vec%0d.active", i),32'(s_act), 32'(tbl[i].act));
      check($sformatf("s_vec%0d.x", i),     32'(s_x),   32'(tbl[i].x));
      check($sformatf("s_vec%0d.y", i),     32'(s_y),   32'(tbl[i].y));
      check($sformatf("s_vec%0d.line_end", i),  32'(s_le), 32'(tbl[i].le));
      check($sformatf("s_vec%0d.frame_end", i), 32'(s_fe), 32'(tbl[i].fe));
    end

    // ------- small instance: vertical sync and frame wrap -------
    s_rst = 1'b0;
    s_en  = 1'b1;
    repeat (32) tick();                       // (0,4): vsync line
    check("s_v4.vcnt",   32'(s_v),   32'd4);
    check("s_v4.vsync",  32'(s_vs),  32'd1);
    check("s_v4.active", 32'(s_act), 32'd0);
    check("s_v4.y",      32'(s_y),   32'd0);
    repeat (8) tick();                        // (0,5): back porch
    check("s_v5.vsync",  32'(s_vs),  32'd0);
    repeat (7) tick();                        // (7,5): last pixel of frame
    check("s_last.hcnt",      32'(s_h),  32'd7);
    check("s_last.line_end",  32'(s_le), 32'd1);
    check("s_last.frame_end", 32'(s_fe), 32'd1);
    s_en = 1'b0;
    #1;
    check("s_last_en0.line_end",  32'(s_le), 32'd0);
    check("s_last_en0.frame_end", 32'(s_fe), 32'd0);
    s_en = 1'b1;
    tick();
    check("s_wrap.hcnt",      32'(s_h),   32'd0);
    check("s_wrap.vcnt",      32'(s_v),   32'd0);
    check("s_wrap.active",    32'(s_act), 32'd1);
    check("s_wrap.frame_end", 32'(s_fe),  32'd0);
    s_en = 1'b0;

    // ------- default instance: reset state -------
    d_rst = 1'b1;
    d_en  = 1'b0;
    tick();
    check("d_rst.hcnt",   32'(d_h),   32'd0);
    check("d_rst.vcnt",   32'(d_v),   32'd0);
    check("d_rst.hsync",  32'(d_hs),  32'd1);
    check("d_rst.vsync",  32'(d_vs),  32'd1);
    check("d_rst.active", 32'(d_act), 32'd1);
    check("d_rst.x",      32'(d_x),   32'd0);
    check("d_rst.y",      32'(d_y),   32'd0);

    // ------- default instance: one full line -------
    d_rst = 1'b0;
    d_en  = 1'b1;
    le_cnt = 0; le_h = -1; hs_cnt = 0; hs_first = -1; hs_last = -1;
    act_cnt = 0; xy_bad = 0;
    for (int i = 0; i < 800; i++) begin
      if (d_le) begin
        le_cnt++;
        le_h = int'(d_h);
      end
      if (!d_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(d_h);
        hs_last = int'(d_h);
      end
      if (d_act) act_cnt++;
      if (d_act ? (d_x != d_h || d_y != d_v) : (d_x != 10'd0 || d_y != 10'd0)) xy_bad++;
      tick();
    end
    check("d_line.line_end_count", 32'(le_cnt),   32'd1);
    check("d_line.line_end_hcnt",  32'(le_h),     32'd799);
    check("d_line.hsync_low_count",32'(hs_cnt),   32'd96);
    check("d_line.hsync_first",    32'(hs_first), 32'd656);
    check("d_line.hsync_last",     32'(hs_last),  32'd751);
    check("d_line.active_count",   32'(act_cnt),  32'd640);
    check("d_line.xy_errors",      32'(xy_bad),   32'd0);
    check("d_line.hcnt",           32'(d_h),      32'd0);
    check("d_line.vcnt",           32'(d_v),      32'd1);

    // ------- default instance: reset mid-frame -------
    repeat (300) tick();
    check("d_mid.hcnt", 32'(d_h), 32'd300);
    check("d_mid.x",    32'(d_x), 32'd300);
    check("d_mid.y",    32'(d_y), 32'd1);
    d_rst = 1'b1;
    tick();
    d_rst = 1'b0;
    check("d_mrst.hcnt",   32'(d_h),   32'd0);
    check("d_mrst.vcnt",   32'(d_v),   32'd0);
    check("d_mrst.x",      32'(d_x),   32'd0);
    check("d_mrst.y",      32'(d_y),   32'd0);
    check("d_mrst.active", 32'(d_act), 32'd1);
    check("d_mrst.hsync",  32'(d_hs),  32'd1);
    check("d_mrst.vsync",  32'(d_vs),  32'd1);

    // ------- default instance: en toggling across a line end -------
    repeat (795) tick();
    exp_h = 795;
    exp_v = 0;
    check("d_tog_start.hcnt", 32'(d_h), 32'(exp_h));
    for (int i = 0; i < 12; i++) begin
      d_en = (i % 2 == 0);
      #1;
      check($sformatf("d_tog%0d.line_end", i),  32'(d_le), 32'(d_en && exp_h == 799));
      check($sformatf("d_tog%0d.frame_end", i), 32'(d_fe), 32'd0);
      tick();
      if (d_en) begin
        if (exp_h == 799) begin
          exp_h = 0;
          exp_v = exp_v + 1;
        end else begin
          exp_h = exp_h + 1;
        end
      end
      check($sformatf("d_tog%0d.hcnt", i), 32'(d_h), 32'(exp_h));
      check($sformatf("d_tog%0d.vcnt", i), 32'(d_v), 32'(exp_v));
    end
    d_en = 1'b0;

    // ------- tall instance: one whole 525-line frame -------
    t_rst = 1'b1;
    tick();
    t_rst = 1'b0;
    t_en  = 1'b1;
    fe_cnt = 0; fe_at = -1; vs_cnt = 0; vs_first = -1; vs_last = -1;
    for (int i = 0; i < 4200; i++) begin
      if (t_fe) begin
        fe_cnt++;
        fe_at = i;
      end
      if (!t_vs) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = int'(t_v);
        vs_last = int'(t_v);
      end
      tick();
    end
    check("t_frame.frame_end_count", 32'(fe_cnt),   32'd1);
    check("t_frame.frame_end_cycle", 32'(fe_at),    32'd4199);
    check("t_frame.vsync_low_count", 32'(vs_cnt),   32'd16);
    check("t_frame.vsync_first",     32'(vs_first), 32'd490);
    check("t_frame.vsync_last",      32'(vs_last),  32'd491);
    check("t_frame.hcnt",            32'(t_h),      32'd0);
    check("t_frame.vcnt",            32'(t_v),      32'd0);
    check("t_frame.active",          32'(t_act),    32'd1);
    check("t_frame.x",               32'(t_x),      32'd0);
    check("t_frame.y",               32'(t_y),      32'd0);

    // ------- tall instance: reset inside both sync pulses -------
    repeat (3933) tick();                     // (5,491)
    check("t_sync.hcnt",  32'(t_h),  32'd5);
    check("t_sync.vcnt",  32'(t_v),  32'd491);
    check("t_sync.hsync", 32'(t_hs), 32'd0);
    check("t_sync.vsync", 32'(t_vs), 32'd0);
    t_rst = 1'b1;
    tick();
    t_rst = 1'b0;
    t_en  = 1'b0;
    check("t_srst.hcnt",   32'(t_h),   32'd0);
    check("t_srst.vcnt",   32'(t_v),   32'd0);
    check("t_srst.hsync",  32'(t_hs),  32'd1);
    check("t_srst.vsync",  32'(t_vs),  32'd1);
    check("t_srst.active", 32'(t_act), 32'd1);

    // ------- report -------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
